dvd_motion_ctrl: RTL and testbench
==================================

Name: dvd_motion_ctrl

Overview:
Sequences the bouncing-pixel position for the one-pixel DVD screensaver. It detects frame starts from the VGA vsync and applies a programmable frame divider. It handles pause and single-step control, then advances the pixel's tile coordinates with edge bounce. It sits between hvsync_generator (vsync source) and the pixel-compare/colour logic, which consumes pos_x/pos_y and color_idx.

Parameters:
X_MAX, 19, last legal tile column (inclusive)
Y_MAX, 14, last legal tile row (inclusive)
XW, 5, width of pos_x
YW, 4, width of pos_y
X_INIT, 0, pos_x after reset/load
Y_INIT, 1, pos_y after reset/load
DIV_W, 4, width of speed divider

Ports:
clk  in  1  system clock (pixel clock)
reset  in  1  asynchronous, active-high reset
vsync  in  1  vsync from hvsync_generator, synchronous to clk
enable  in  1  level; 0 freezes all motion and the divider
pause  in  1  level; 1 requests paused mode
step  in  1  one-cycle pulse; arms a single move while paused
load  in  1  one-cycle pulse; reload X_INIT/Y_INIT and directions
init_dir  in  2  {dir_x, dir_y} loaded on load
speed  in  DIV_W  move once every speed+1 frames
pos_x  out  XW  current tile column
pos_y  out  YW  current tile row
dir_x  out  1  1 = moving right
dir_y  out  1  1 = moving down
frame_tick  out  1  one-cycle pulse per vsync rising edge
bounce  out  1  one-cycle pulse when any axis flips direction
corner  out  1  one-cycle pulse when both axes flip on the same move
color_idx  out  3  increments on every bounce; wraps 7->0

Behaviour:
- Reset (async, all registers): vsync_q=1 (suppresses a spurious first tick), div_cnt=0, state=RUN, pos_x=X_INIT, pos_y=Y_INIT, dir_x=1, dir_y=1, frame_tick=0, bounce=0, corner=0, color_idx=0.
- Edge detect: frame_tick <= vsync & ~vsync_q (registered). It is asserted in the cycle after vsync is first sampled high. It pulses regardless of enable.
- Move strobe (internal) is qualified by frame_tick & enable:
  - RUN: if div_cnt == speed, then move, div_cnt <= 0; else div_cnt++.
  - speed is sampled at each tick; speed=0 means move every frame.
  - If div_cnt > speed after speed is lowered, treat it as a match (move, clear).
- FSM states RUN, PAUSED, STEP_ARMED:
  - RUN -> PAUSED when pause=1 (checked every cycle). A move coinciding with that cycle still executes.
  - PAUSED -> RUN when pause=0. PAUSED -> STEP_ARMED on step.
  - STEP_ARMED: on the next qualified tick, execute one move (ignores the divider), then go to PAUSED. If pause drops while armed -> RUN.
  - step in RUN is ignored.
  - div_cnt holds while not RUN.
- Move (per axis, registered, lands one cycle after frame_tick, i.e. two clk cycles after vsync rises):
  - dir=1 and pos >= MAX: flip dir, hold pos.
  - dir=1 otherwise: pos+1.
  - dir=0 and pos == 0: flip dir, hold pos.
  - dir=0 otherwise: pos-1.
  - A flip consumes the move (no position change on the bounce frame).
- bounce/corner are registered in the same cycle as the position update and are one-cycle pulses.
- color_idx += 1 on bounce. A corner counts once.
- load (synchronous) has the highest priority. It sets pos_x=X_INIT, pos_y=Y_INIT, {dir_x,dir_y}=init_dir, div_cnt=0, state=RUN (if pause=1, next cycle goes to PAUSED). It suppresses any coincident move, bounce and corner. color_idx is unchanged.
- enable=0: no moves; state transitions on pause/step still occur; step stays armed.
- Reset asserted mid-frame or mid-move: all outputs return to reset values immediately. After deassertion, the first tick needs a fresh vsync rising edge.

Decomposition:
- Package dvd_pkg:
  - state enum {RUN, PAUSED, STEP_ARMED}
  - default X_MAX/Y_MAX/XW/YW constants, shared with the pixel-compare logic
- Sub-module dvd_axis_stepper, instantiated twice (x, y):
  - parameters: width, MAX
  - inputs: move, load, load_dir, init pos
  - outputs: pos, dir, flip pulse
- Top: edge detect, divider, FSM, bounce/corner/color aggregation.

Test Plan:
- Reset, vsync idle high then low, then one 0->1 edge -> frame_tick exactly once, 1 cycle after the edge; first edge after reset with vsync held high yields no tick.
- speed=0, init_dir=2'b11, load, 20 vsync edges -> pos_x 0->19 with pos_y 1->14 then hold; at pos_y=14 the next move gives bounce=1, dir_y=0, pos_y stays 14, color_idx=1.
- speed=2 -> position changes only on every 3rd tick (ticks 3, 6, 9); speed changed 3->0 mid-count with div_cnt=2 -> move on the next tick.
- Drive pos to (19,14) moving right/down -> single move gives corner=1, bounce=1, both dirs flip, color_idx +1 only.
- pause=1, 5 ticks -> no motion; step pulse then 2 ticks -> exactly one move; pause=0 -> resumes on divider schedule with div_cnt from held value.
- Assert reset between tick and move cycle -> pos=(X_INIT,Y_INIT), dirs=1, no bounce pulse; load coincident with a move tick -> loaded values win, no bounce.

Source files
------------

// File: rtl/dvd_pkg.sv
// Shared constants for the one-pixel DVD screensaver.
// Provides the default tile-grid geometry, which the pixel-compare logic also
// uses, and the motion FSM state encoding.
package dvd_pkg;

  localparam int X_MAX_DEF = 19;
  localparam int Y_MAX_DEF = 14;
  localparam int XW_DEF    = 5;
  localparam int YW_DEF    = 4;
  localparam int DIV_W_DEF = 4;

  // Plain constants keep the encoding fixed for older tools that read these.
  typedef logic [1:0] state_t;
  localparam state_t ST_RUN        = 2'd0;
  localparam state_t ST_PAUSED     = 2'd1;
  localparam state_t ST_STEP_ARMED = 2'd2;

endpackage

// File: rtl/dvd_axis_stepper.sv
// One axis of the bouncing pixel: position plus travel direction.
// Ports:
//   clk, reset     clock, async active-high reset (pos=INIT, dir=1)
//   move_i         advance one step this cycle
//   load_i         reload init_pos_i / load_dir_i (wins over move_i)
//   load_dir_i     direction loaded on load_i
//   init_pos_i     position loaded on load_i
//   pos_o, dir_o   registered position / direction (1 = increasing)
//   flip_o         combinational: this cycle's move reverses direction,
//                  so the parent can register it alongside pos_o
module dvd_axis_stepper #(
  parameter int W    = 5,
  parameter int MAX  = 19,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         move_i,
  input  logic         load_i,
  input  logic         load_dir_i,
  input  logic [W-1:0] init_pos_i,
  output logic [W-1:0] pos_o,
  output logic         dir_o,
  output logic         flip_o
);

  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] INIT_V = W'(INIT);

  logic [W-1:0] pos_q, pos_d;
  logic         dir_q, dir_d;
  logic         at_edge;

  // >= rather than == so an out-of-range init still turns back.
  assign at_edge = dir_q ? (pos_q >= MAX_V) : (pos_q == '0);
  assign flip_o  = move_i & ~load_i & at_edge;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (load_i) begin
      pos_d = init_pos_i;
      dir_d = load_dir_i;
    end else if (move_i) begin
      // A bounce spends the whole move on turning around.
      if (at_edge)    dir_d = ~dir_q;
      else if (dir_q) pos_d = pos_q + 1'b1;
      else            pos_d = pos_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= INIT_V;
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos_o = pos_q;
  assign dir_o = dir_q;

endmodule

// File: rtl/dvd_motion_ctrl.sv
// Motion sequencer for the one-pixel DVD screensaver.
// Turns vsync rising edges into frame ticks, divides them by speed+1,
// applies pause / single-step control and moves the pixel with edge bounce.
// Ports:
//   clk, reset            pixel clock, async active-high reset
//   vsync                 from hvsync_generator (clk domain)
//   enable                0 freezes motion and the divider
//   pause, step           pause level / single-move pulse while paused
//   load, init_dir        reload start position and {dir_x, dir_y}
//   speed                 move once every speed+1 frames
//   pos_x, pos_y          tile coordinates
//   dir_x, dir_y          1 = right / down
//   frame_tick            pulse per vsync rising edge
//   bounce, corner        pulse on any / both axis flips
//   color_idx             bumps by one per bounce
module dvd_motion_ctrl import dvd_pkg::*; #(
  parameter int X_MAX  = X_MAX_DEF,
  parameter int Y_MAX  = Y_MAX_DEF,
  parameter int XW     = XW_DEF,
  parameter int YW     = YW_DEF,
  parameter int X_INIT = 0,
  parameter int Y_INIT = 1,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             enable,
  input  logic             pause,
  input  logic             step,
  input  logic             load,
  input  logic [1:0]       init_dir,
  input  logic [DIV_W-1:0] speed,
  output logic [XW-1:0]    pos_x,
  output logic [YW-1:0]    pos_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic             frame_tick,
  output logic             bounce,
  output logic             corner,
  output logic [2:0]       color_idx
);

  localparam logic [XW-1:0] X_INIT_V = XW'(X_INIT);
  localparam logic [YW-1:0] Y_INIT_V = YW'(Y_INIT);

  logic             vsync_q, tick_q;
  logic [DIV_W-1:0] div_q, div_d;
  state_t           st_q, st_d;
  logic             bounce_q, corner_q;
  logic [2:0]       color_q, color_d;

  logic qual, div_hit, move_run, move_step, move;
  logic flip_x, flip_y;

  // Qualified frame: the tick itself ignores enable, motion does not.
  assign qual      = tick_q & enable;
  // >= so lowering speed below the running count fires on the next frame.
  assign div_hit   = (div_q >= speed);
  assign move_run  = qual & (st_q == ST_RUN) & div_hit;
  assign move_step = qual & (st_q == ST_STEP_ARMED);
  assign move      = (move_run | move_step) & ~load;

  always_comb begin
    st_d  = st_q;
    div_d = div_q;
    if (load) begin
      st_d  = ST_RUN;
      div_d = '0;
    end else begin
      case (st_q)
        ST_RUN: begin
          if (qual) div_d = div_hit ? '0 : div_q + 1'b1;
          if (pause) st_d = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (!pause)    st_d = ST_RUN;
          else if (step) st_d = ST_STEP_ARMED;
        end
        ST_STEP_ARMED: begin
          if (!pause)         st_d = ST_RUN;
          else if (move_step) st_d = ST_PAUSED;
        end
        default: st_d = ST_RUN;
      endcase
    end
  end

  dvd_axis_stepper #(.W(XW), .MAX(X_MAX), .INIT(X_INIT)) u_x (
    .clk        (clk),
    .reset      (reset),
    .move_i     (move),
    .load_i     (load),
    .load_dir_i (init_dir[1]),
    .init_pos_i (X_INIT_V),
    .pos_o      (pos_x),
    .dir_o      (dir_x),
    .flip_o     (flip_x)
  );

  dvd_axis_stepper #(.W(YW), .MAX(Y_MAX), .INIT(Y_INIT)) u_y (
    .clk        (clk),
    .reset      (reset),
    .move_i     (move),
    .load_i     (load),
    .load_dir_i (init_dir[0]),
    .init_pos_i (Y_INIT_V),
    .pos_o      (pos_y),
    .dir_o      (dir_y),
    .flip_o     (flip_y)
  );

  // A corner flips both axes but still counts as a single colour change.
  assign color_d = (flip_x | flip_y) ? color_q + 3'd1 : color_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q  <= 1'b1;  // no tick if vsync is already high out of reset
      tick_q   <= 1'b0;
      div_q    <= '0;
      st_q     <= ST_RUN;
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      color_q  <= 3'd0;
    end else begin
      vsync_q  <= vsync;
      tick_q   <= vsync & ~vsync_q;
      div_q    <= div_d;
      st_q     <= st_d;
      bounce_q <= flip_x | flip_y;
      corner_q <= flip_x & flip_y;
      color_q  <= color_d;
    end
  end

  assign frame_tick = tick_q;
  assign bounce     = bounce_q;
  assign corner     = corner_q;
  assign color_idx  = color_q;

endmodule

// File: tb/tb_dvd_motion_ctrl.sv
module tb_dvd_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset, vsync, enable, pause, step, load;
  logic [1:0] init_dir;
  logic [3:0] speed;

  // main instance: default start (0,1)
  logic [4:0] pos_x;   logic [3:0] pos_y;
  logic       dir_x, dir_y, frame_tick, bounce, corner;
  logic [2:0] color_idx;
  // corner instance: starts at (18,13), one move from the far corner
  logic [4:0] pos_x_k; logic [3:0] pos_y_k;
  logic       dir_x_k, dir_y_k, frame_tick_k, bounce_k, corner_k;
  logic [2:0] color_idx_k;

  int n_chk = 0;
  int n_fail = 0;
  logic f_tick, f_b, f_c, f_bk, f_ck, any;

  always #5 clk = ~clk;

  dvd_motion_ctrl dut (
    .clk(clk), .reset(reset), .vsync(vsync), .enable(enable), .pause(pause),
    .step(step), .load(load), .init_dir(init_dir), .speed(speed),
    .pos_x(pos_x), .pos_y(pos_y), .dir_x(dir_x), .dir_y(dir_y),
    .frame_tick(frame_tick), .bounce(bounce), .corner(corner), .color_idx(color_idx)
  );

  dvd_motion_ctrl #(.X_INIT(18), .Y_INIT(13)) dut_k (
    .clk(clk), .reset(reset), .vsync(vsync), .enable(enable), .pause(pause),
    .step(step), .load(load), .init_dir(init_dir), .speed(speed),
    .pos_x(pos_x_k), .pos_y(pos_y_k), .dir_x(dir_x_k), .dir_y(dir_y_k),
    .frame_tick(frame_tick_k), .bounce(bounce_k), .corner(corner_k), .color_idx(color_idx_k)
  );

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One vsync frame: rise, tick cycle, move cycle (pulses captured), low.
  task automatic frame();
    vsync = 1'b1;
    cyc(1); f_tick = frame_tick;
    cyc(1); f_b = bounce; f_c = corner; f_bk = bounce_k; f_ck = corner_k;
    vsync = 1'b0;
    cyc(2);
  endtask

  task automatic do_load(input logic [1:0] d);
    init_dir = d; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; vsync = 1'b1; enable = 1'b0; pause = 1'b0; step = 1'b0;
    load = 1'b0; init_dir = 2'b11; speed = 4'd0;
    cyc(3);
    reset = 1'b0;
    n_chk++; if ({pos_x, pos_y, dir_x, dir_y} !== {5'd0, 4'd1, 2'b11}) begin n_fail++;
      $display("FAIL reset_pos: got %0d,%0d dir %b%b want 0,1 dir 11", pos_x, pos_y, dir_x, dir_y); end
    n_chk++; if ({frame_tick, bounce, corner, color_idx} !== 6'd0) begin n_fail++;
      $display("FAIL reset_flags: got %b want 000000", {frame_tick, bounce, corner, color_idx}); end
    n_chk++; if ({pos_x_k, pos_y_k} !== {5'd18, 4'd13}) begin n_fail++;
      $display("FAIL reset_pos_k: got %0d,%0d want 18,13", pos_x_k, pos_y_k); end
    any = 1'b0;
    repeat (3) begin cyc(1); any |= frame_tick; end
    n_chk++; if (any !== 1'b0) begin n_fail++;
      $display("FAIL tick_held_high: got %b want 0", any); end
    vsync = 1'b0; cyc(2);
    vsync = 1'b1;
    n_chk++; if (frame_tick !== 1'b0) begin n_fail++;
      $display("FAIL tick_early: got %b want 0", frame_tick); end
    cyc(1);
    n_chk++; if (frame_tick !== 1'b1) begin n_fail++;
      $display("FAIL tick_edge: got %b want 1", frame_tick); end
    cyc(1);
    n_chk++; if (frame_tick !== 1'b0) begin n_fail++;
      $display("FAIL tick_width: got %b want 0", frame_tick); end
    vsync = 1'b0; cyc(2);
    n_chk++; if ({pos_x, pos_y} !== {5'd0, 4'd1}) begin n_fail++;
      $display("FAIL enable_freeze: got %0d,%0d want 0,1", pos_x, pos_y); end
    enable = 1'b1;
  endtask

  task automatic test_corner();
    speed = 4'd0;
    do_load(2'b11);
    frame();
    n_chk++; if ({pos_x_k, pos_y_k, f_bk} !== {5'd19, 4'd14, 1'b0}) begin n_fail++;
      $display("FAIL corner_approach: got %0d,%0d b%b want 19,14 b0", pos_x_k, pos_y_k, f_bk); end
    frame();
    n_chk++; if ({f_bk, f_ck, dir_x_k, dir_y_k} !== 4'b1100) begin n_fail++;
      $display("FAIL corner_pulse: got b%b c%b dir %b%b want b1 c1 dir 00", f_bk, f_ck, dir_x_k, dir_y_k); end
    n_chk++; if ({pos_x_k, pos_y_k, color_idx_k} !== {5'd19, 4'd14, 3'd1}) begin n_fail++;
      $display("FAIL corner_hold: got %0d,%0d col %0d want 19,14 col 1", pos_x_k, pos_y_k, color_idx_k); end
    n_chk++; if ({pos_x, pos_y, f_b} !== {5'd2, 4'd3, 1'b0}) begin n_fail++;
      $display("FAIL corner_main: got %0d,%0d b%b want 2,3 b0", pos_x, pos_y, f_b); end
    frame();
    n_chk++; if ({pos_x_k, pos_y_k, f_bk, f_ck, color_idx_k} !== {5'd18, 4'd13, 2'b00, 3'd1}) begin n_fail++;
      $display("FAIL corner_after: got %0d,%0d b%b c%b col %0d want 18,13 b0 c0 col 1",
               pos_x_k, pos_y_k, f_bk, f_ck, color_idx_k); end
  endtask

  task automatic test_sweep();
    speed = 4'd0;
    do_load(2'b11);
    any = 1'b0;
    for (int i = 0; i < 13; i++) begin frame(); any |= f_b; end
    n_chk++; if ({pos_x, pos_y, dir_x, dir_y, any, color_idx} !== {5'd13, 4'd14, 2'b11, 1'b0, 3'd0}) begin n_fail++;
      $display("FAIL sweep_13: got %0d,%0d dir %b%b b%b col %0d want 13,14 dir 11 b0 col 0",
               pos_x, pos_y, dir_x, dir_y, any, color_idx); end
    frame();
    n_chk++; if ({f_b, f_c, pos_x, pos_y, dir_x, dir_y, color_idx} !== {2'b10, 5'd14, 4'd14, 2'b10, 3'd1}) begin n_fail++;
      $display("FAIL sweep_ybounce: got b%b c%b %0d,%0d dir %b%b col %0d want b1 c0 14,14 dir 10 col 1",
               f_b, f_c, pos_x, pos_y, dir_x, dir_y, color_idx); end
    for (int i = 0; i < 5; i++) frame();
    n_chk++; if ({pos_x, pos_y, f_b} !== {5'd19, 4'd9, 1'b0}) begin n_fail++;
      $display("FAIL sweep_19: got %0d,%0d b%b want 19,9 b0", pos_x, pos_y, f_b); end
    frame();
    n_chk++; if ({f_b, pos_x, pos_y, dir_x, dir_y, color_idx} !== {1'b1, 5'd19, 4'd8, 2'b00, 3'd2}) begin n_fail++;
      $display("FAIL sweep_xbounce: got b%b %0d,%0d dir %b%b col %0d want b1 19,8 dir 00 col 2",
               f_b, pos_x, pos_y, dir_x, dir_y, color_idx); end
  endtask

  task automatic test_divider();
    speed = 4'd2;
    do_load(2'b11);
    n_chk++; if (color_idx !== 3'd2) begin n_fail++;
      $display("FAIL load_keeps_color: got %0d want 2", color_idx); end
    frame(); frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd0, 4'd1}) begin n_fail++;
      $display("FAIL div_tick2: got %0d,%0d want 0,1", pos_x, pos_y); end
    frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd1, 4'd2}) begin n_fail++;
      $display("FAIL div_tick3: got %0d,%0d want 1,2", pos_x, pos_y); end
    frame(); frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd1, 4'd2}) begin n_fail++;
      $display("FAIL div_tick5: got %0d,%0d want 1,2", pos_x, pos_y); end
    frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd2, 4'd3}) begin n_fail++;
      $display("FAIL div_tick6: got %0d,%0d want 2,3", pos_x, pos_y); end
    speed = 4'd3;
    do_load(2'b11);
    frame(); frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd0, 4'd1}) begin n_fail++;
      $display("FAIL div3_hold: got %0d,%0d want 0,1", pos_x, pos_y); end
    speed = 4'd0;
    frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd1, 4'd2}) begin n_fail++;
      $display("FAIL div_lowered: got %0d,%0d want 1,2", pos_x, pos_y); end
    frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd2, 4'd3}) begin n_fail++;
      $display("FAIL div_every: got %0d,%0d want 2,3", pos_x, pos_y); end
  endtask

  task automatic test_pause_step();
    speed = 4'd1;
    do_load(2'b11);
    frame();
    pause = 1'b1; cyc(1);
    for (int i = 0; i < 5; i++) frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd0, 4'd1}) begin n_fail++;
      $display("FAIL paused_hold: got %0d,%0d want 0,1", pos_x, pos_y); end
    step = 1'b1; cyc(1); step = 1'b0;
    frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd1, 4'd2}) begin n_fail++;
      $display("FAIL step_move: got %0d,%0d want 1,2", pos_x, pos_y); end
    frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd1, 4'd2}) begin n_fail++;
      $display("FAIL step_once: got %0d,%0d want 1,2", pos_x, pos_y); end
    pause = 1'b0;
    frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd2, 4'd3}) begin n_fail++;
      $display("FAIL resume_held_div: got %0d,%0d want 2,3", pos_x, pos_y); end
    frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd2, 4'd3}) begin n_fail++;
      $display("FAIL resume_skip: got %0d,%0d want 2,3", pos_x, pos_y); end
    frame();
    n_chk++; if ({pos_x, pos_y} !== {5'd3, 4'd4}) begin n_fail++;
      $display("FAIL resume_move: got %0d,%0d want 3,4", pos_x, pos_y); end
  endtask

  task automatic test_reset_mid();
    speed = 4'd0;
    do_load(2'b11);
    frame();
    vsync = 1'b1; cyc(1);
    reset = 1'b1; #1;
    n_chk++; if ({pos_x, pos_y, dir_x, dir_y, pos_x_k, pos_y_k, dir_x_k, dir_y_k}
                 !== {5'd0, 4'd1, 2'b11, 5'd18, 4'd13, 2'b11}) begin n_fail++;
      $display("FAIL rst_mid_pos: got %0d,%0d %0d,%0d want 0,1 18,13", pos_x, pos_y, pos_x_k, pos_y_k); end
    n_chk++; if ({frame_tick, bounce_k, corner_k, color_idx} !== 6'd0) begin n_fail++;
      $display("FAIL rst_mid_flags: got %b want 000000", {frame_tick, bounce_k, corner_k, color_idx}); end
    @(posedge clk); #1;
    n_chk++; if ({bounce_k, pos_x_k, pos_y_k} !== {1'b0, 5'd18, 4'd13}) begin n_fail++;
      $display("FAIL rst_mid_nomove: got b%b %0d,%0d want b0 18,13", bounce_k, pos_x_k, pos_y_k); end
    reset = 1'b0;
    any = 1'b0;
    repeat (3) begin cyc(1); any |= frame_tick; end
    n_chk++; if (any !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_tick: got %b want 0", any); end
    vsync = 1'b0; cyc(2);
  endtask

  task automatic test_load_coincide();
    frame();
    n_chk++; if ({pos_x, pos_y, pos_x_k, pos_y_k} !== {5'd1, 4'd2, 5'd19, 4'd14}) begin n_fail++;
      $display("FAIL lc_pre: got %0d,%0d %0d,%0d want 1,2 19,14", pos_x, pos_y, pos_x_k, pos_y_k); end
    vsync = 1'b1; cyc(1);
    load = 1'b1; init_dir = 2'b00;
    cyc(1);
    load = 1'b0;
    n_chk++; if ({pos_x, pos_y, dir_x, dir_y} !== {5'd0, 4'd1, 2'b00}) begin n_fail++;
      $display("FAIL lc_main: got %0d,%0d dir %b%b want 0,1 dir 00", pos_x, pos_y, dir_x, dir_y); end
    n_chk++; if ({pos_x_k, pos_y_k, dir_x_k, dir_y_k, bounce_k, corner_k, color_idx_k}
                 !== {5'd18, 4'd13, 2'b00, 2'b00, 3'd0}) begin n_fail++;
      $display("FAIL lc_k: got %0d,%0d dir %b%b b%b c%b col %0d want 18,13 dir 00 b0 c0 col 0",
               pos_x_k, pos_y_k, dir_x_k, dir_y_k, bounce_k, corner_k, color_idx_k); end
    vsync = 1'b0; cyc(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_corner();
    test_sweep();
    test_divider();
    test_pause_step();
    test_reset_mid();
    test_load_coincide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
